// File: rtl/data_path.sv
// Accumulator data path: an add/subtract ALU feeding a registered accumulator.
// The accumulator is loaded from data memory, from the sign-extended
// instruction operand, or from the ALU result, or it holds its value.
// The operand field is also forwarded unchanged toward the data-memory address/data path.
module data_path #(
    parameter int DATA_W = 16,
    parameter int OPD_W  = 11
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [OPD_W-1:0]  OPERAND_IN,
    input  logic [DATA_W-1:0] DM_IN,
    input  logic [1:0]        SEL_A,
    input  logic              SEL_B,
    input  logic              WR_ACC,
    input  logic              OP,
    output logic [DATA_W-1:0] ACC,
    output logic [OPD_W-1:0]  OPERAND_OUT
);

    localparam logic [1:0] SRC_DM   = 2'd0;
    localparam logic [1:0] SRC_OPD  = 2'd1;
    localparam logic [1:0] SRC_ALU  = 2'd2;
    localparam logic [1:0] SRC_HOLD = 2'd3;

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] ext_opd;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] acc_next;

    // Sign-extend the operand field; the loop also covers DATA_W == OPD_W.
    always_comb begin
        ext_opd = '0;
        ext_opd[OPD_W-1:0] = OPERAND_IN;
        for (int i = OPD_W; i < DATA_W; i++) begin
            ext_opd[i] = OPERAND_IN[OPD_W-1];
        end
    end

    // ALU on the pre-edge accumulator; carry/borrow fall off the top bit.
    always_comb begin
        alu_b   = SEL_B ? ext_opd : DM_IN;
        alu_res = OP ? (acc_q - alu_b) : (acc_q + alu_b);
    end

    // Accumulator source select.
    always_comb begin
        acc_next = acc_q;
        case (SEL_A)
            SRC_DM:   acc_next = DM_IN;
            SRC_OPD:  acc_next = ext_opd;
            SRC_ALU:  acc_next = alu_res;
            SRC_HOLD: acc_next = acc_q;
            default:  acc_next = acc_q;
        endcase
    end

    // Accumulator register; reset clears it immediately, independent of the clock.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc_q <= '0;
        end else if (WR_ACC) begin
            acc_q <= acc_next;
        end
    end

    assign ACC         = acc_q;
    assign OPERAND_OUT = OPERAND_IN;

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: each driven edge pushes the model's
// expected accumulator value, which is popped and compared after the edge.
module tb_data_path;

    localparam int DW = 16;
    localparam int OW = 11;

    logic          clk;
    logic          rst;
    logic [OW-1:0] operand_in;
    logic [DW-1:0] dm_in;
    logic [1:0]    sel_a;
    logic          sel_b;
    logic          wr_acc;
    logic          op;
    logic [DW-1:0] acc;
    logic [OW-1:0] operand_out;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_acc;
    logic [DW-1:0] exp_q[$];

    data_path #(.DATA_W(DW), .OPD_W(OW)) dut (
        .CLK        (clk),
        .RESET      (rst),
        .OPERAND_IN (operand_in),
        .DM_IN      (dm_in),
        .SEL_A      (sel_a),
        .SEL_B      (sel_b),
        .WR_ACC     (wr_acc),
        .OP         (op),
        .ACC        (acc),
        .OPERAND_OUT(operand_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of one clock edge.
    function automatic logic [DW-1:0] model_next(input logic [DW-1:0] a);
        logic [DW-1:0] ext;
        logic [DW-1:0] b;
        logic [DW-1:0] res;
        ext = {{(DW-OW){operand_in[OW-1]}}, operand_in};
        b   = (sel_b == 1'b1) ? ext : dm_in;
        res = (op == 1'b1) ? DW'(a - b) : DW'(a + b);
        if (rst || !wr_acc) return a;
        case (sel_a)
            2'd0:    return dm_in;
            2'd1:    return ext;
            2'd2:    return res;
            default: return a;
        endcase
    endfunction

    // Push the expected value for the current inputs, then advance one edge.
    task automatic drive_edge();
        model_acc = model_next(model_acc);
        exp_q.push_back(model_acc);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic set_in(input logic [1:0] a, input logic b, input logic o,
                          input logic w, input logic [OW-1:0] opd,
                          input logic [DW-1:0] dm);
        sel_a = a; sel_b = b; op = o; wr_acc = w; operand_in = opd; dm_in = dm;
    endtask

    task automatic test_reset();
        logic [DW-1:0] e;
        rst = 1'b1;
        set_in(2'd0, 1'b0, 1'b0, 1'b1, 11'h05A, 16'd10);
        #1;
        checks++;
        if (acc !== 16'h0000) begin
            errors++; $display("FAIL reset_initial acc=%h exp=0000", acc);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (acc !== 16'h0000) begin
                errors++; $display("FAIL reset_hold acc=%h exp=0000", acc);
            end
            checks++;
            if (operand_out !== 11'h05A) begin
                errors++; $display("FAIL reset_opd_out out=%h exp=05a", operand_out);
            end
        end
        rst = 1'b0;
        model_acc = '0;
        drive_edge();
        e = pop_exp();
        checks++;
        if (acc !== e || e !== 16'd10) begin
            errors++; $display("FAIL reset_release acc=%h exp=%h", acc, e);
        end
        sel_a = 2'd1; operand_in = 11'd0;
        drive_edge();
        e = pop_exp();
        checks++;
        if (acc !== e) begin
            errors++; $display("FAIL clear_acc acc=%h exp=%h", acc, e);
        end
    endtask

    task automatic test_subtract();
        logic [DW-1:0] e;
        set_in(2'd2, 1'b0, 1'b1, 1'b1, 11'd0, 16'd10);
        drive_edge();
        e = pop_exp();
        checks++;
        if (acc !== e || e !== 16'hFFF6) begin
            errors++; $display("FAIL sub_dm_1 acc=%h exp=fff6", acc);
        end
        drive_edge();
        e = pop_exp();
        checks++;
        if (acc !== e || e !== 16'hFFEC) begin
            errors++; $display("FAIL sub_dm_2 acc=%h exp=ffec", acc);
        end
    endtask

    task automatic test_operand_sub();
        logic [DW-1:0] e;
        set_in(2'd0, 1'b0, 1'b0, 1'b1, 11'd0, 16'hFFF6);
        drive_edge();
        void'(pop_exp());
        set_in(2'd2, 1'b1, 1'b1, 1'b1, 11'd15, 16'h0000);
        #2;
        checks++;
        if (operand_out !== 11'd15) begin
            errors++; $display("FAIL opd_out_comb out=%h exp=00f", operand_out);
        end
        drive_edge();
        e = pop_exp();
        checks++;
        if (acc !== e || e !== 16'hFFE7) begin
            errors++; $display("FAIL sub_opd acc=%h exp=ffe7", acc);
        end
    endtask

    task automatic test_sign_ext();
        logic [DW-1:0] e;
        set_in(2'd1, 1'b0, 1'b0, 1'b1, 11'h7FF, 16'h0000);
        drive_edge();
        e = pop_exp();
        checks++;
        if (acc !== e || e !== 16'hFFFF) begin
            errors++; $display("FAIL sext_neg acc=%h exp=ffff", acc);
        end
        operand_in = 11'h3FF;
        drive_edge();
        e = pop_exp();
        checks++;
        if (acc !== e || e !== 16'h03FF) begin
            errors++; $display("FAIL sext_pos acc=%h exp=03ff", acc);
        end
    endtask

    task automatic test_wrap_hold();
        logic [DW-1:0] e;
        set_in(2'd0, 1'b0, 1'b0, 1'b1, 11'd0, 16'h7FFF);
        drive_edge();
        void'(pop_exp());
        set_in(2'd2, 1'b1, 1'b0, 1'b1, 11'd1, 16'h0000);
        drive_edge();
        e = pop_exp();
        checks++;
        if (acc !== e || e !== 16'h8000) begin
            errors++; $display("FAIL wrap acc=%h exp=8000", acc);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin sel_a = 2'd3; wr_acc = 1'b1; end
            else        begin sel_a = 2'd2; wr_acc = 1'b0; end
            dm_in = 16'h1111; op = i[0];
            drive_edge();
            e = pop_exp();
            checks++;
            if (acc !== e || e !== 16'h8000) begin
                errors++; $display("FAIL hold_%0d acc=%h exp=8000", i, acc);
            end
        end
    endtask

    task automatic test_load_reset();
        logic [DW-1:0] e;
        set_in(2'd0, 1'b0, 1'b0, 1'b1, 11'h123, 16'h1234);
        drive_edge();
        e = pop_exp();
        checks++;
        if (acc !== e || e !== 16'h1234) begin
            errors++; $display("FAIL load_dm acc=%h exp=1234", acc);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (acc !== 16'h0000) begin
            errors++; $display("FAIL async_reset acc=%h exp=0000", acc);
        end
        model_acc = '0;
        @(posedge clk); #1;
        checks++;
        if (acc !== 16'h0000) begin
            errors++; $display("FAIL reset_over_wr acc=%h exp=0000", acc);
        end
        operand_in = 11'h2AA;
        #1;
        checks++;
        if (operand_out !== 11'h2AA) begin
            errors++; $display("FAIL opd_out_in_reset out=%h exp=2aa", operand_out);
        end
        rst = 1'b0;
        drive_edge();
        e = pop_exp();
        checks++;
        if (acc !== e || e !== 16'h1234) begin
            errors++; $display("FAIL first_after_reset acc=%h exp=1234", acc);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        for (int i = 0; i < 40; i++) begin
            set_in(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                   11'($urandom), 16'($urandom));
            drive_edge();
            e = pop_exp();
            checks++;
            if (acc !== e) begin
                errors++; $display("FAIL random_%0d acc=%h exp=%h", i, acc, e);
            end
            checks++;
            if (operand_out !== operand_in) begin
                errors++; $display("FAIL random_opd_%0d out=%h exp=%h", i, operand_out, operand_in);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        model_acc = '0;
        set_in(2'd0, 1'b0, 1'b0, 1'b0, 11'd0, 16'd0);
        test_reset();
        test_subtract();
        test_operand_sub();
        test_sign_ext();
        test_wrap_hold();
        test_load_reset();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover size=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_path.md
DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter DATA_W, default 16: accumulator, data-memory and ALU width; SHALL be >= OPD_W.
REQ-003 Parameter OPD_W, default 11: instruction operand width.
REQ-004 CLK  input  1  clock; all state changes on rising edge.
REQ-005 RESET  input  1  asynchronous active-high reset.
REQ-006 OPERAND_IN  input  OPD_W  instruction operand field, two's complement.
REQ-007 DM_IN  input  DATA_W  data-memory read data.
REQ-008 SEL_A  input  2  accumulator source select.
REQ-009 SEL_B  input  1  ALU second-operand select.
REQ-010 WR_ACC  input  1  accumulator write enable.
REQ-011 OP  input  1  ALU operation: 0 = add, 1 = subtract.
REQ-012 ACC  output  DATA_W  registered accumulator value.
REQ-013 OPERAND_OUT  output  OPD_W  operand forwarded to data-memory address/data path.

Function
REQ-014 ext_opd SHALL be OPERAND_IN sign-extended to DATA_W bits (bit OPD_W-1 replicated).
REQ-015 ALU operand B SHALL be DM_IN when SEL_B=0 and ext_opd when SEL_B=1.
REQ-016 ALU result SHALL be ACC + B when OP=0 and ACC - B when OP=1, combinational, modulo 2^DATA_W.
REQ-017 Overflow, carry and borrow SHALL be discarded; no flags are produced.
REQ-018 Accumulator next value SHALL be: SEL_A=0 -> DM_IN; SEL_A=1 -> ext_opd; SEL_A=2 -> ALU result; SEL_A=3 -> current ACC (hold).
REQ-019 On a rising CLK edge with WR_ACC=1 and RESET=0, ACC SHALL load the selected next value; with WR_ACC=0, ACC SHALL hold.
REQ-020 Latency: a write SHALL be visible on ACC one clock edge after the controlling inputs are stable; ACC SHALL not change between edges.
REQ-021 ALU SHALL always use the pre-edge ACC value, so repeated writes with SEL_A=2 accumulate once per edge.
REQ-022 OPERAND_OUT SHALL equal OPERAND_IN combinationally, zero latency, independent of clock and reset.
REQ-023 SEL_B and OP SHALL have no effect on ACC unless SEL_A=2 and WR_ACC=1.

Reset
REQ-024 While RESET=1, ACC SHALL be 0 immediately, independent of CLK.
REQ-025 RESET asserted mid-operation SHALL override WR_ACC; the first write after release SHALL occur on the first rising edge with RESET=0.
REQ-026 OPERAND_OUT SHALL keep tracking OPERAND_IN during reset.

Verification
REQ-027 RESET=1, WR_ACC=1, DM_IN=10 -> ACC=0x0000 throughout; release RESET -> next edge loads per selects.
REQ-028 From ACC=0: SEL_A=2, SEL_B=0, OP=1, DM_IN=10, WR_ACC=1, one edge -> ACC=0xFFF6 (-10); second edge -> 0xFFEC (-20).
REQ-029 From ACC=0xFFF6: SEL_A=2, SEL_B=1, OP=1, OPERAND_IN=15, one edge -> ACC=0xFFE7 (-25); OPERAND_OUT=15 at all times.
REQ-030 SEL_A=1, OPERAND_IN=0x7FF, edge -> ACC=0xFFFF; OPERAND_IN=0x3FF, edge -> ACC=0x03FF (sign extension).
REQ-031 ACC=0x7FFF, SEL_A=2, SEL_B=1, OP=0, OPERAND_IN=1, edge -> ACC=0x8000 (wrap, no flag); then WR_ACC=0 or SEL_A=3 for 3 edges -> ACC stays 0x8000.
REQ-032 SEL_A=0, DM_IN=0x1234, WR_ACC=1, edge -> ACC=0x1234; assert RESET between edges -> ACC=0 before next edge.
